// File: rtl/mimo_inst_fifo.sv
// mimo_inst_fifo: banked multi-write/multi-read FWFT instruction buffer between fetch and decode.
module mimo_inst_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16,
   parameter int BANK       = 2,
   parameter int WRITE_PORT = 2,
   parameter int READ_PORT  = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush_i,
   input  logic                                write_valid_i,
   output logic                                write_ready_o,
   input  logic [$clog2(WRITE_PORT+1)-1:0]     write_num_i,
   input  logic [WRITE_PORT*DATA_WIDTH-1:0]    write_data_i,
   output logic [READ_PORT-1:0]                read_valid_o,
   input  logic                                read_ready_i,
   input  logic [$clog2(READ_PORT+1)-1:0]      read_num_i,
   output logic [READ_PORT*DATA_WIDTH-1:0]     read_data_o
);
   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = AW + 1;
   localparam int LB   = $clog2(BANK);
   localparam int ROWS = DEPTH / BANK;
   localparam int WN   = $clog2(WRITE_PORT + 1);
   localparam int RN   = $clog2(READ_PORT + 1);
   logic [PW-1:0] wptr, rptr, count, free, wadv, radv, rnum;
   logic [DATA_WIDTH-1:0] bank_q [BANK];
   assign count         = wptr - rptr;
   assign free          = PW'(DEPTH) - count;
   assign write_ready_o = free >= PW'(WRITE_PORT);
   assign wadv = !(write_valid_i && write_ready_o) ? '0 :
                 (write_num_i > WN'(WRITE_PORT)) ? PW'(WRITE_PORT) : PW'(write_num_i);
   assign rnum = (read_num_i > RN'(READ_PORT)) ? PW'(READ_PORT) : PW'(read_num_i);
   assign radv = !read_ready_i ? '0 : (rnum > count) ? count : rnum;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr + wadv;
         rptr <= rptr + radv;
      end
   end
   // each bank sees at most one write slot and one read slot per cycle
   for (genvar b = 0; b < BANK; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] ram [ROWS];
      logic [PW-1:0] wk, rk, wa, ra;
      logic [DATA_WIDTH-1:0] wd;
      assign wk = (PW'(b) - wptr) & PW'(BANK - 1);
      assign rk = (PW'(b) - rptr) & PW'(BANK - 1);
      assign wa = wptr + wk;
      assign ra = rptr + rk;
      always_comb begin
         wd = '0;
         for (int k = 0; k < WRITE_PORT; k++)
            if (wk == PW'(k)) wd = write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      always_ff @(posedge clk) begin
         if (!flush_i && wk < wadv) ram[wa[AW-1:LB]] <= wd;
      end
      assign bank_q[b] = ram[ra[AW-1:LB]];
   end
   for (genvar i = 0; i < READ_PORT; i++) begin : g_rd
      logic [PW-1:0] sel;
      logic [DATA_WIDTH-1:0] rd;
      assign sel = (rptr + PW'(i)) & PW'(BANK - 1);
      always_comb begin
         rd = '0;
         for (int b = 0; b < BANK; b++)
            if (sel == PW'(b)) rd = bank_q[b];
      end
      assign read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign read_valid_o[i] = count > PW'(i);
   end
endmodule

// File: tb/tb_mimo_inst_fifo.sv
// tb_mimo_inst_fifo: directed vector table plus hand sequences for fill, steady-state wrap and async reset.
module tb_mimo_inst_fifo;
   localparam int DW = 64;
   typedef struct {
      logic fl, wv;
      logic [1:0] wn;
      logic [63:0] d0, d1;
      logic rr;
      logic [1:0] rn;
      logic [1:0] ev;
      logic er;
      logic [63:0] e0, e1;
   } vec_t;
   logic clk = 0, rst_n = 0, flush_i = 0, write_valid_i = 0, read_ready_i = 0;
   logic [1:0] write_num_i = 0, read_num_i = 0;
   logic [2*DW-1:0] write_data_i = '0;
   logic write_ready_o;
   logic [1:0] read_valid_o;
   logic [2*DW-1:0] read_data_o;
   int checks = 0, errors = 0;
   vec_t tbl [15];
   mimo_inst_fifo dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
      .write_num_i(write_num_i), .write_data_i(write_data_i),
      .read_valid_o(read_valid_o), .read_ready_i(read_ready_i),
      .read_num_i(read_num_i), .read_data_o(read_data_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   // inputs change at negedge; outputs sampled 1ns later reflect the state before the coming edge
   task automatic drive(input logic fl, input logic wv, input logic [1:0] wn, input logic [63:0] d0,
                        input logic [63:0] d1, input logic rr, input logic [1:0] rn);
      @(negedge clk);
      flush_i = fl; write_valid_i = wv; write_num_i = wn; write_data_i = {d1, d0};
      read_ready_i = rr; read_num_i = rn;
      #1;
      if (rr && !fl && rn > 2'($countones(read_valid_o))) begin
         errors++;
         $display("FAIL proto read_num %0d valid %b", rn, read_valid_o);
      end
   endtask
   task automatic expect_out(input string nm, input logic [1:0] v, input logic r,
                             input logic [63:0] e0, input logic [63:0] e1);
      chk({nm, ".valid"}, 64'(read_valid_o), 64'(v));
      chk({nm, ".ready"}, 64'(write_ready_o), 64'(r));
      if (v[0]) chk({nm, ".d0"}, read_data_o[DW-1:0], e0);
      if (v[1]) chk({nm, ".d1"}, read_data_o[2*DW-1:DW], e1);
   endtask
   task automatic run_vec(input int i);
      drive(tbl[i].fl, tbl[i].wv, tbl[i].wn, tbl[i].d0, tbl[i].d1, tbl[i].rr, tbl[i].rn);
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].e0, tbl[i].e1);
   endtask
   initial begin
      //            fl wv wn d0      d1      rr rn  ev     er e0      e1
      tbl[0]  = '{0, 0, 0, 0,      0,      0, 0, 2'b00, 1, 0,      0};
      tbl[1]  = '{0, 1, 2, 'hA,    'hB,    0, 0, 2'b00, 1, 0,      0};
      tbl[2]  = '{0, 0, 0, 0,      0,      0, 0, 2'b11, 1, 'hA,    'hB};
      tbl[3]  = '{0, 0, 0, 0,      0,      1, 2, 2'b11, 1, 'hA,    'hB};
      tbl[4]  = '{0, 1, 1, 'hC1,   0,      0, 0, 2'b00, 1, 0,      0};
      tbl[5]  = '{0, 1, 2, 'hC2,   'hC3,   1, 1, 2'b01, 1, 'hC1,   0};
      tbl[6]  = '{0, 0, 0, 0,      0,      0, 0, 2'b11, 1, 'hC2,   'hC3};
      tbl[7]  = '{0, 0, 0, 0,      0,      1, 2, 2'b11, 1, 'hC2,   'hC3};
      tbl[8]  = '{0, 1, 2, 'h51,   'h52,   0, 0, 2'b00, 1, 0,      0};
      tbl[9]  = '{0, 1, 2, 'h53,   'h54,   0, 0, 2'b11, 1, 'h51,   'h52};
      tbl[10] = '{0, 1, 1, 'h55,   0,      0, 0, 2'b11, 1, 'h51,   'h52};
      tbl[11] = '{1, 1, 2, 'h56,   'h57,   1, 2, 2'b11, 1, 'h51,   'h52};
      tbl[12] = '{0, 1, 1, 'hEE,   0,      0, 0, 2'b00, 1, 0,      0};
      tbl[13] = '{0, 0, 0, 0,      0,      0, 0, 2'b01, 1, 'hEE,   0};
      tbl[14] = '{0, 0, 0, 0,      0,      1, 1, 2'b01, 1, 'hEE,   0};
      #2;
      expect_out("reset", 2'b00, 1, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 15; i++) run_vec(i);
      for (int i = 0; i < 15; i++) begin
         drive(0, 1, 1, 64'(100 + i), 0, 0, 0);
         chk("fill.ready", 64'(write_ready_o), 1);
      end
      drive(0, 1, 1, 'hDEAD, 0, 0, 0);
      expect_out("full", 2'b11, 0, 100, 101);
      drive(0, 0, 0, 0, 0, 1, 2);
      chk("full.ready_hold", 64'(write_ready_o), 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("after_read", 2'b11, 1, 102, 103);
      for (int t = 102; t < 115; t += 2) begin
         drive(0, 0, 0, 0, 0, 1, (t == 114) ? 2'd1 : 2'd2);
         chk("drain.d0", read_data_o[DW-1:0], 64'(t));
         if (t < 114) chk("drain.d1", read_data_o[2*DW-1:DW], 64'(t + 1));
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("drained", 2'b00, 1, 0, 0);
      drive(0, 1, 2, 0, 1, 0, 0);
      for (int c = 1; c < 40; c++) begin
         drive(0, 1, 2, 64'(2 * c), 64'(2 * c + 1), 1, 2);
         expect_out($sformatf("steady%0d", c), 2'b11, 1, 64'(2 * c - 2), 64'(2 * c - 1));
      end
      drive(0, 0, 0, 0, 0, 1, 2);
      expect_out("steady_end", 2'b11, 1, 78, 79);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("steady_empty", 2'b00, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 2, 64'(200 + 2 * i), 64'(201 + 2 * i), 0, 0);
      drive(0, 1, 1, 208, 0, 0, 0);
      drive(0, 1, 2, 209, 210, 0, 0);
      expect_out("occ9", 2'b11, 1, 200, 201);
      #2 rst_n = 0;
      #1 expect_out("async_reset", 2'b00, 1, 0, 0);
      write_valid_i = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 3; i++) run_vec(i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mimo_inst_fifo.md
Name: mimo_inst_fifo

Overview:
Banked multi-write/multi-read instruction buffer between the instruction-fetch stage and the decode/issue stage of the frontend.
- Each cycle it accepts 0..WRITE_PORT fetched instruction packages (pc, inst, fetch exception, branch prediction) in order.
- It presents the oldest READ_PORT packages to the decoders with first-word-fall-through timing.
- It retires 0..READ_PORT packages per cycle.
- Redirects (rst_jmp) empty it through flush_i.

Parameters:
DATA_WIDTH, 64, bits per package (frontend sets 64 + prediction + exception widths)
DEPTH, 16, total entries; power of two; multiple of BANK
BANK, 2, number of storage banks; power of two; must be >= max(WRITE_PORT, READ_PORT)
WRITE_PORT, 2, maximum packages written per cycle
READ_PORT, 2, maximum packages read per cycle

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  discard all contents; takes priority over read and write
write_valid_i  in  1  write request qualifier
write_ready_o  out  1  free entries >= WRITE_PORT
write_num_i  in  $clog2(WRITE_PORT+1)  number of packages to write, 0..WRITE_PORT
write_data_i  in  WRITE_PORT*DATA_WIDTH  packed array; slot 0 is the oldest; slots >= write_num_i are ignored
read_valid_o  out  READ_PORT  bit i = entry rptr+i holds data (thermometer code)
read_ready_i  in  1  read request qualifier
read_num_i  in  $clog2(READ_PORT+1)  number of packages consumed, 0..READ_PORT
read_data_o  out  READ_PORT*DATA_WIDTH  slot i = entry rptr+i

Behaviour:
Pointers and occupancy:
- wptr and rptr are $clog2(DEPTH)+1 bits, counting entries, with a wrap bit.
- count = wptr - rptr, modulo 2^(ptr width).
- Logical entry e maps to bank e % BANK, row (e % DEPTH) / BANK.
- Consecutive entries therefore fall in distinct banks, so every write slot and every read slot hits a different bank each cycle.

Reset (async, rst_n=0):
- wptr = rptr = 0.
- read_valid_o = 0.
- write_ready_o = 1, since count = 0 and DEPTH >= WRITE_PORT.
- Storage RAM is not reset.
- Reset asserted mid-operation drops all contents immediately.

Write:
- Fires when write_valid_i && write_ready_o.
- Slot k (k < write_num_i) is stored to entry wptr+k.
- wptr advances by write_num_i on the next edge.
- write_num_i = 0 is legal and is a no-op.
- write_ready_o = (DEPTH - count) >= WRITE_PORT, computed from the registered count only.
- write_ready_o is never combinationally dependent on read_num_i, which keeps the fetch stall path short.
- When write_ready_o = 0, the write is dropped and the producer holds its data.

Read:
- read_valid_o[i] = (count > i).
- read_data_o[i] = storage[rptr+i], combinational from the registered pointer, i.e. zero-latency FWFT.
- Fires when read_ready_i; rptr advances by min(read_num_i, count).
- read_num_i > count is a protocol violation. The block clamps it, and the bench asserts it never occurs.

Simultaneous read and write:
- Both apply in the same cycle: count_next = count + writes - reads.
- A write never overwrites an unread entry, because readiness is computed on the pre-read count.
- Data written this cycle is visible on read_data_o no earlier than the next cycle, so an empty FIFO stays empty for one cycle.

Flush:
- wptr and rptr return to 0 at the next edge.
- Any write and read in the same cycle are discarded.
- read_valid_o is not masked combinationally during the flush cycle; the consumer masks with the same signal.
- Flush while full or empty behaves identically.

Wrap-around:
- Pointers wrap modulo 2*DEPTH.
- Full is detected as count == DEPTH, i.e. equal index with differing wrap bits.
- Reads and writes that straddle the DEPTH-1 -> 0 boundary keep correct order and bank mapping.

Test Plan:
1. Reset, then idle -> read_valid_o=00, write_ready_o=1. Write 2 packages A,B -> next cycle read_valid_o=11, read_data_o[0]=A, read_data_o[1]=B.
2. Write 1 package per cycle for 15 cycles with no reads -> count=15, write_ready_o=0. A write attempted in cycle 16 is dropped. Read 2 -> next cycle write_ready_o=1.
3. Steady state with 2 writes + 2 reads per cycle for 40 cycles, sequential tags 0..79 -> outputs appear in order 0..79 with no gaps across pointer wrap (DEPTH=16). count stays constant.
4. Occupancy 1 (tag X) and write_num=2 (Y,Z), read_num=1 in the same cycle -> next cycle read_valid_o=11, data Y,Z.
5. Occupancy 5, flush_i=1 together with write_num=2 and read_num=2 -> next cycle read_valid_o=00, write_ready_o=1. A subsequent write of W appears as read_data_o[0]=W.
6. Assert rst_n=0 asynchronously mid-burst with occupancy 9 -> read_valid_o=00 before the next clock edge. After release, behaviour is identical to scenario 1.
